// File: rtl/rs_issue_scheduler.sv
// rs_issue_scheduler: busy/age tracking, dual-slot allocation and oldest-first dual issue for a reservation station
// Ports:
//   clock, reset (sync, active-high), flush (squash all entries)
//   dispatch_valid -> alloc_grant, alloc_idx0/1, alloc_load (entry load strobes)
//   entry_ready, fu_avail -> issue_valid, issue_idx0/1, issue_use (entry use/free strobes)
//   free_count, rs_full: registered occupancy reported to dispatch
module rs_issue_scheduler #(
    parameter int RS_SIZE = 8,
    parameter int AGE_W   = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [1:0]                   dispatch_valid,
    output logic [1:0]                   alloc_grant,
    output logic [$clog2(RS_SIZE)-1:0]   alloc_idx0,
    output logic [$clog2(RS_SIZE)-1:0]   alloc_idx1,
    output logic [RS_SIZE-1:0]           alloc_load,
    input  logic [RS_SIZE-1:0]           entry_ready,
    input  logic [1:0]                   fu_avail,
    output logic [1:0]                   issue_valid,
    output logic [$clog2(RS_SIZE)-1:0]   issue_idx0,
    output logic [$clog2(RS_SIZE)-1:0]   issue_idx1,
    output logic [RS_SIZE-1:0]           issue_use,
    output logic [$clog2(RS_SIZE+1)-1:0] free_count,
    output logic                         rs_full
);
    localparam int IW = $clog2(RS_SIZE);
    localparam int CW = $clog2(RS_SIZE+1);
    logic [RS_SIZE-1:0] busy;
    logic [AGE_W-1:0]   age [RS_SIZE];
    logic               f0, f1, h0, h1, live;
    logic [IW-1:0]      o0, o1;
    logic [AGE_W-1:0]   ab0, ab1;
    logic [RS_SIZE-1:0] cand;
    assign live = !reset && !flush;
    assign cand = busy & entry_ready;
    assign rs_full = free_count == '0;
    // lowest and second-lowest free entries
    always_comb begin
        alloc_idx0 = '0;
        alloc_idx1 = '0;
        f0 = 1'b0;
        f1 = 1'b0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (!busy[i] && !f0) begin
                alloc_idx0 = IW'(i);
                f0 = 1'b1;
            end else if (!busy[i] && !f1) begin
                alloc_idx1 = IW'(i);
                f1 = 1'b1;
            end
        end
    end
    assign alloc_grant[0] = live && dispatch_valid[0] && free_count >= CW'(1);
    assign alloc_grant[1] = live && dispatch_valid[1] && alloc_grant[0] && free_count >= CW'(2);
    assign alloc_load = (alloc_grant[0] ? RS_SIZE'(1) << alloc_idx0 : '0) |
                        (alloc_grant[1] ? RS_SIZE'(1) << alloc_idx1 : '0);
    // oldest and next-oldest candidates; strict compare keeps the lower index on ties
    always_comb begin
        h0 = 1'b0;
        h1 = 1'b0;
        o0 = '0;
        o1 = '0;
        ab0 = '0;
        ab1 = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (cand[i] && (!h0 || age[i] > ab0)) begin
                h0 = 1'b1;
                o0 = IW'(i);
                ab0 = age[i];
            end
        end
        for (int i = 0; i < RS_SIZE; i++) begin
            if (cand[i] && IW'(i) != o0 && (!h1 || age[i] > ab1)) begin
                h1 = 1'b1;
                o1 = IW'(i);
                ab1 = age[i];
            end
        end
    end
    // oldest goes to the lowest available port; port 1 gets the oldest when port 0 is busy
    assign issue_valid[0] = live && fu_avail[0] && h0;
    assign issue_valid[1] = live && fu_avail[1] && (fu_avail[0] ? h1 : h0);
    assign issue_idx0 = o0;
    assign issue_idx1 = fu_avail[0] ? o1 : o0;
    assign issue_use = (issue_valid[0] ? RS_SIZE'(1) << issue_idx0 : '0) |
                       (issue_valid[1] ? RS_SIZE'(1) << issue_idx1 : '0);
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            busy <= '0;
            free_count <= CW'(RS_SIZE);
            for (int i = 0; i < RS_SIZE; i++) age[i] <= '0;
        end else begin
            free_count <= free_count - CW'(alloc_grant[0]) - CW'(alloc_grant[1])
                          + CW'(issue_valid[0]) + CW'(issue_valid[1]);
            for (int i = 0; i < RS_SIZE; i++) begin
                if (alloc_load[i]) begin
                    busy[i] <= 1'b1;
                    age[i] <= '0;
                end else if (issue_use[i]) begin
                    busy[i] <= 1'b0;
                end else if (busy[i]) begin
                    age[i] <= (&age[i]) ? age[i] : age[i] + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_rs_issue_scheduler.sv
// tb_rs_issue_scheduler: directed vectors with a queued scoreboard checked by an independent monitor
module tb_rs_issue_scheduler;
    localparam int X = -1;
    logic       clock = 0, reset = 1, flush = 0;
    logic [1:0] dispatch_valid = 0, fu_avail = 0;
    logic [7:0] entry_ready = 0;
    logic [1:0] alloc_grant, issue_valid;
    logic [2:0] alloc_idx0, alloc_idx1, issue_idx0, issue_idx1;
    logic [7:0] alloc_load, issue_use;
    logic [3:0] free_count;
    logic       rs_full;
    int checks = 0, errors = 0;

    typedef struct {
        string tag;
        int g, a0, a1, ld, iv, i0, i1, us, fc, fl;
    } exp_t;
    exp_t q[$];

    rs_issue_scheduler #(.RS_SIZE(8), .AGE_W(4)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .dispatch_valid(dispatch_valid), .alloc_grant(alloc_grant),
        .alloc_idx0(alloc_idx0), .alloc_idx1(alloc_idx1), .alloc_load(alloc_load),
        .entry_ready(entry_ready), .fu_avail(fu_avail), .issue_valid(issue_valid),
        .issue_idx0(issue_idx0), .issue_idx1(issue_idx1), .issue_use(issue_use),
        .free_count(free_count), .rs_full(rs_full)
    );

    always #5 clock = ~clock;

    function automatic void chk(input string tag, input string f, input int act, input int ex);
        if (ex < 0) return;
        checks++;
        if (act != ex) begin
            errors++;
            $display("FAIL %s %s got %0d want %0d", tag, f, act, ex);
        end
    endfunction

    task automatic cyc(input logic r, input logic f, input logic [1:0] dv, input logic [7:0] rdy,
                       input logic [1:0] fu, input string tag, input int g, input int a0, input int a1,
                       input int iv, input int i0, input int i1, input int us, input int fc, input int fl);
        exp_t e;
        @(posedge clock);
        #1;
        reset = r;
        flush = f;
        dispatch_valid = dv;
        entry_ready = rdy;
        fu_avail = fu;
        e.tag = tag; e.g = g; e.a0 = a0; e.a1 = a1; e.iv = iv; e.i0 = i0; e.i1 = i1;
        e.us = us; e.fc = fc; e.fl = fl;
        e.ld = X;
        if (g == 0) e.ld = 0;
        else if (g == 1 && a0 >= 0) e.ld = 1 << a0;
        else if (g == 3 && a0 >= 0 && a1 >= 0) e.ld = (1 << a0) | (1 << a1);
        q.push_back(e);
    endtask

    initial forever begin
        exp_t e;
        @(negedge clock);
        if (q.size() > 0) begin
            e = q.pop_front();
            chk(e.tag, "alloc_grant", int'(alloc_grant), e.g);
            chk(e.tag, "alloc_idx0", int'(alloc_idx0), e.a0);
            chk(e.tag, "alloc_idx1", int'(alloc_idx1), e.a1);
            chk(e.tag, "alloc_load", int'(alloc_load), e.ld);
            chk(e.tag, "issue_valid", int'(issue_valid), e.iv);
            chk(e.tag, "issue_idx0", int'(issue_idx0), e.i0);
            chk(e.tag, "issue_idx1", int'(issue_idx1), e.i1);
            chk(e.tag, "issue_use", int'(issue_use), e.us);
            chk(e.tag, "free_count", int'(free_count), e.fc);
            chk(e.tag, "rs_full", int'(rs_full), e.fl);
        end
    end

    initial begin
        // 1: fill in pairs, then full
        cyc(1,0,2'b11,8'hff,2'b11,"rst_a", 0,X,X, 0,X,X,0, X,X);
        cyc(1,0,2'b11,8'hff,2'b11,"rst_b", 0,X,X, 0,X,X,0, 8,0);
        cyc(0,0,2'b11,8'h00,2'b11,"t1_a",  3,0,1, 0,X,X,0, 8,0);
        cyc(0,0,2'b11,8'h00,2'b11,"t1_b",  3,2,3, 0,X,X,0, 6,0);
        cyc(0,0,2'b11,8'h00,2'b11,"t1_c",  3,4,5, 0,X,X,0, 4,0);
        cyc(0,0,2'b11,8'h00,2'b11,"t1_d",  3,6,7, 0,X,X,0, 2,0);
        cyc(0,0,2'b01,8'h00,2'b11,"t1_full",0,X,X, 0,X,X,0, 0,1);
        // 2: ages now 5,5,4,4,3,3,2,2 after one more idle cycle
        cyc(0,0,2'b00,8'h00,2'b11,"t2_wait",0,X,X, 0,X,X,0, 0,1);
        cyc(0,0,2'b00,8'b1010_0100,2'b11,"t2_iss",0,X,X, 3,2,5,8'b0010_0100, 0,1);
        cyc(0,0,2'b00,8'b1000_0000,2'b11,"t2_nxt",0,X,X, 1,7,X,8'h80, 2,0);
        // 3: entry0 age 5, entry1 age 3, only port 1 free
        cyc(1,0,2'b00,8'h00,2'b00,"rst3",  0,X,X, 0,X,X,0, X,X);
        cyc(0,0,2'b01,8'h00,2'b00,"t3_a0", 1,0,X, 0,X,X,0, 8,0);
        cyc(0,0,2'b00,8'h00,2'b00,"t3_w0", 0,X,X, 0,X,X,0, 7,0);
        cyc(0,0,2'b01,8'h00,2'b00,"t3_a1", 1,1,X, 0,X,X,0, 7,0);
        cyc(0,0,2'b00,8'h00,2'b00,"t3_w1", 0,X,X, 0,X,X,0, 6,0);
        cyc(0,0,2'b00,8'h00,2'b00,"t3_w2", 0,X,X, 0,X,X,0, 6,0);
        cyc(0,0,2'b00,8'h00,2'b00,"t3_w3", 0,X,X, 0,X,X,0, 6,0);
        cyc(0,0,2'b00,8'h03,2'b10,"t3_iss",0,X,X, 2,X,0,8'h01, 6,0);
        cyc(0,0,2'b00,8'h02,2'b01,"t3_rem",0,X,X, 1,1,X,8'h02, 7,0);
        // 4: full RS, entry 4 issues while slot 0 dispatches
        cyc(1,0,2'b00,8'h00,2'b00,"rst4",  0,X,X, 0,X,X,0, X,X);
        cyc(0,0,2'b11,8'h00,2'b00,"t4_f0", 3,0,1, 0,X,X,0, 8,0);
        cyc(0,0,2'b11,8'h00,2'b00,"t4_f1", 3,2,3, 0,X,X,0, 6,0);
        cyc(0,0,2'b11,8'h00,2'b00,"t4_f2", 3,4,5, 0,X,X,0, 4,0);
        cyc(0,0,2'b11,8'h00,2'b00,"t4_f3", 3,6,7, 0,X,X,0, 2,0);
        cyc(0,0,2'b01,8'h10,2'b01,"t4_n",  0,X,X, 1,4,X,8'h10, 0,1);
        cyc(0,0,2'b01,8'h00,2'b00,"t4_n1", 1,4,X, 0,X,X,0, 1,0);
        // 5: one free entry with both slots requested; slot 1 alone on an empty RS
        cyc(0,0,2'b00,8'h01,2'b01,"t5_iss",0,X,X, 1,0,X,8'h01, 0,1);
        cyc(0,0,2'b11,8'h00,2'b00,"t5_g1", 1,0,X, 0,X,X,0, 1,0);
        cyc(1,0,2'b00,8'h00,2'b00,"rst5",  0,X,X, 0,X,X,0, X,X);
        cyc(0,0,2'b10,8'h00,2'b00,"t5_s1", 0,X,X, 0,X,X,0, 8,0);
        // 6: flush with 5 busy, 2 ready, dispatch pending; then reset mid-fill
        cyc(0,0,2'b11,8'h00,2'b00,"t6_f0", 3,0,1, 0,X,X,0, 8,0);
        cyc(0,0,2'b11,8'h00,2'b00,"t6_f1", 3,2,3, 0,X,X,0, 6,0);
        cyc(0,0,2'b01,8'h00,2'b00,"t6_f2", 1,4,X, 0,X,X,0, 4,0);
        cyc(0,1,2'b11,8'h03,2'b11,"t6_fl", 0,X,X, 0,X,X,0, 3,0);
        cyc(0,0,2'b01,8'h00,2'b00,"t6_post",1,0,X, 0,X,X,0, 8,0);
        cyc(0,0,2'b11,8'h00,2'b00,"t6_g",  3,1,2, 0,X,X,0, 7,0);
        cyc(1,0,2'b11,8'hff,2'b11,"t6_rst",0,X,X, 0,X,X,0, 5,0);
        cyc(0,0,2'b00,8'h00,2'b00,"t6_rpost",0,X,X, 0,X,X,0, 8,0);
        repeat (3) @(negedge clock);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rs_issue_scheduler.md
Name: rs_issue_scheduler

Overview:
- Occupancy, allocation and issue controller for an RS_SIZE-entry reservation station in the 2-way superscalar core.
- Allocation: grants up to two in-order dispatch slots per cycle into free entries and drives the entries' load strobes.
- Issue: selects up to two oldest ready entries per cycle for the FU ports and drives the entries' use_enable/free strobes.
- Tracks per-entry busy bits and age counters; reports free count and full status to dispatch.

Parameters:
RS_SIZE, 8, number of RS entries (power of 2, >=4)
AGE_W, 4, width of per-entry saturating age counter

Ports:
clock  input  1  clock
reset  input  1  synchronous, active-high reset
flush  input  1  squash all entries (branch mispredict)
dispatch_valid  input  2  dispatch slot requests; bit0 is older than bit1
alloc_grant  output  2  slot accepted this cycle (combinational)
alloc_idx0  output  $clog2(RS_SIZE)  entry assigned to slot 0
alloc_idx1  output  $clog2(RS_SIZE)  entry assigned to slot 1
alloc_load  output  RS_SIZE  one-hot OR of granted entries; drives the entries' load_in
entry_ready  input  RS_SIZE  per-entry operands-valid flag from the entries
fu_avail  input  2  issue port n can accept an instruction this cycle
issue_valid  output  2  issue port n carries an instruction (combinational)
issue_idx0  output  $clog2(RS_SIZE)  entry issued on port 0
issue_idx1  output  $clog2(RS_SIZE)  entry issued on port 1
issue_use  output  RS_SIZE  one-hot OR of issued entries; drives the entries' use_enable and free_in
free_count  output  $clog2(RS_SIZE+1)  number of non-busy entries (registered state)
rs_full  output  1  free_count == 0

Behaviour:
- State: busy[RS_SIZE] and age[RS_SIZE][AGE_W].
- Reset: busy = 0, age = 0. While reset is high, alloc_grant, alloc_load, issue_valid and issue_use are forced to 0. After reset, free_count = RS_SIZE and rs_full = 0.
- Free set: entries with busy == 0 at the start of the cycle. An entry issued in cycle N is not reallocated before cycle N+1.
- Allocation:
  - alloc_idx0 = lowest free index; alloc_idx1 = second-lowest free index.
  - alloc_grant[0] = dispatch_valid[0] && free_count >= 1.
  - alloc_grant[1] = dispatch_valid[1] && alloc_grant[0] && free_count >= 2. Slot 1 is never granted without slot 0, so dispatch_valid = 2'b10 yields grant 00.
  - Idx outputs are don't-care when the corresponding grant is 0.
- Issue candidates: busy & entry_ready. A newly allocated entry cannot issue in its allocation cycle.
- Age order: higher age is older; ties go to the lower index.
  - The oldest candidate goes to the lowest-numbered port with fu_avail = 1.
  - The next-oldest candidate goes to the remaining available port, if any.
  - issue_valid[n] = 1 only if port n is available and was assigned a candidate.
- Next state (cycle N+1):
  - busy set for granted entries; busy cleared for issued entries.
  - age = 0 for granted entries.
  - Every other busy, non-issued entry increments age, saturating at 2^AGE_W-1.
  - Issued entries' age becomes don't-care (reset on next allocation).
- Ordering: two grants in the same cycle give slot 0 the lower index, so the tie-break keeps slot 0 older. Saturation can erase ordering between very old entries; falling back to lowest index is the accepted behaviour.
- Simultaneous events: allocation and issue in the same cycle touch disjoint entries (free vs busy) and both take effect.
- free_count next = free_count - popcount(alloc_grant) + popcount(issue_valid).
- Flush:
  - Grants and issues are suppressed in the flush cycle.
  - Next cycle: busy = 0, age = 0, free_count = RS_SIZE.
  - Flush has priority over any allocation or issue in the same cycle.
  - Reset has priority over flush.

Test Plan:
1. Reset, then dispatch_valid = 11 with entry_ready = 0 for 4 cycles. Required: grants 11 every cycle, idx pairs (0,1), (2,3), (4,5), (6,7), then free_count = 0 and rs_full = 1. A fifth dispatch_valid = 01 gets grant 00.
2. Fill entries 0..7 in order (two per cycle), wait 2 cycles, set entry_ready = 8'b1010_0100 with fu_avail = 11. Required: issue_idx0 = 2, issue_idx1 = 5, issue_use = 8'b0010_0100. Next cycle: free_count = 2 and entry 7 issues on port 0.
3. With fu_avail = 10 and two ready entries of ages 3 and 5. Required: issue_valid = 10 and port 1 carries the age-5 entry. Next cycle the age-3 entry (now age 4) remains busy.
4. RS full; entry 4 issues in cycle N while dispatch_valid = 01. Required: grant 00 in cycle N, grant 01 with alloc_idx0 = 4 in cycle N+1.
5. Free_count = 1 with dispatch_valid = 11. Required: grant 01. Separately, dispatch_valid = 10 with RS empty. Required: grant 00.
6. Flush asserted with 5 busy entries, 2 ready, and a dispatch pending. Required: issue_valid = 00 and alloc_grant = 00 in the flush cycle, then free_count = 8. Also assert reset mid-fill and check the same empty state.
